// File: rtl/arena_pkg.sv
// Shared encodings for the arena loader: cell codes, game states, layout modes, LFSR defaults.
package arena_pkg;

    typedef enum logic [1:0] {
        CELL_BLANK    = 2'b00,
        CELL_BLOCK    = 2'b01,
        CELL_PLAYER_A = 2'b10,
        CELL_PLAYER_B = 2'b11
    } cell_t;

    typedef enum logic [1:0] {
        GS_PLAY    = 2'd0,
        GS_LOADING = 2'd3
    } game_state_t;

    typedef enum logic [1:0] {
        MODE_EMPTY   = 2'd0,
        MODE_PILLARS = 2'd1,
        MODE_LEGACY  = 2'd2,
        MODE_RANDOM  = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_FINISH = 2'd2
    } ld_state_t;

    localparam int unsigned LFSR_W            = 16;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    // Fibonacci LFSR step, taps 16,14,13,11.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

endpackage

// File: rtl/arena_loader_if.sv
// Load-request and arena write bus between a game controller and the arena loader.
interface arena_loader_if #(
    parameter int unsigned ROWS = 10,
    parameter int unsigned COLS = 10
);
    localparam int unsigned AW = $clog2(ROWS * COLS);

    logic                   start;
    logic [1:0]             mode;
    logic [15:0]            seed;
    logic                   busy;
    logic                   done;
    logic                   cell_we;
    logic [AW-1:0]          cell_addr;
    arena_pkg::cell_t       cell_data;
    logic                   bomb_we;
    logic [1:0]             healthA;
    logic [1:0]             healthB;
    arena_pkg::game_state_t game_state;

    modport master (
        output start, mode, seed,
        input  busy, done, cell_we, cell_addr, cell_data, bomb_we,
               healthA, healthB, game_state
    );

    modport slave (
        input  start, mode, seed,
        output busy, done, cell_we, cell_addr, cell_data, bomb_we,
               healthA, healthB, game_state
    );
endinterface

// File: rtl/arena_lfsr.sv
// 16-bit random source for the random arena layout: loadable, advance on demand.
module arena_lfsr
    import arena_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    input  logic              advance,
    output logic [LFSR_W-1:0] value
);

    // Load takes priority over advance; reset returns to the default seed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value <= LFSR_DEFAULT_SEED;
        end else if (load) begin
            value <= load_val;
        end else if (advance) begin
            value <= lfsr_step(value);
        end
    end

endmodule

// File: rtl/arena_loader.sv
// Arena loader: writes every cell of the arena once in row-major order, then arms the game.
module arena_loader
    import arena_pkg::*;
#(
    parameter int unsigned ROWS        = 10,
    parameter int unsigned COLS        = 10,
    parameter int unsigned HEALTH_INIT = 3,
    parameter int unsigned DENSITY     = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    arena_loader_if.slave bus
);

    localparam int unsigned CELLS = ROWS * COLS;
    localparam int unsigned AW    = $clog2(CELLS);
    localparam int unsigned RW    = $clog2(ROWS);
    localparam int unsigned CW    = $clog2(COLS);

    ld_state_t         state_q, state_d;
    logic [RW-1:0]     r_q, r_d;
    logic [CW-1:0]     c_q, c_d;
    logic [AW-1:0]     base_q, base_d;
    mode_t             mode_q, mode_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              we_q, we_d;
    logic [AW-1:0]     addr_q, addr_d;
    cell_t             data_q, data_d;
    logic [1:0]        ha_q, ha_d;
    logic [1:0]        hb_q, hb_d;
    game_state_t       gs_q, gs_d;

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_seed;
    logic              lfsr_load;
    logic              lfsr_adv;
    logic              lfsr_unused;

    logic [RW-1:0]     nr;
    logic [CW-1:0]     nc;
    logic [AW-1:0]     nbase;
    logic              emit;

    // Random source for mode 3.
    arena_lfsr u_lfsr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (lfsr_load),
        .load_val (lfsr_seed),
        .advance  (lfsr_adv),
        .value    (lfsr_q)
    );

    assign lfsr_unused = ^lfsr_q[15:4];

    function automatic logic is_border(input logic [RW-1:0] r, input logic [CW-1:0] c);
        return (r == '0) || (r == RW'(ROWS - 1)) || (c == '0) || (c == CW'(COLS - 1));
    endfunction

    function automatic logic is_spawn_a(input logic [RW-1:0] r, input logic [CW-1:0] c);
        return (r == RW'(1)) && (c == CW'(1));
    endfunction

    function automatic logic is_spawn_b(input logic [RW-1:0] r, input logic [CW-1:0] c);
        return (r == RW'(ROWS - 2)) && (c == CW'(COLS - 2));
    endfunction

    // Interior cells orthogonally next to a spawn stay clear so players can move.
    function automatic logic is_safe(input logic [RW-1:0] r, input logic [CW-1:0] c);
        return ((r == RW'(1))        && (c == CW'(2)))        ||
               ((r == RW'(2))        && (c == CW'(1)))        ||
               ((r == RW'(ROWS - 3)) && (c == CW'(COLS - 2))) ||
               ((r == RW'(ROWS - 2)) && (c == CW'(COLS - 3)));
    endfunction

    // Cells whose code is decided by the selected layout mode.
    function automatic logic is_rule(input logic [RW-1:0] r, input logic [CW-1:0] c);
        return !is_border(r, c) && !is_spawn_a(r, c) && !is_spawn_b(r, c) && !is_safe(r, c);
    endfunction

    // Fixed block layout carried over from the original 10x10 game.
    function automatic logic legacy_hit(input logic [AW-1:0] a);
        if ((ROWS != 10) || (COLS != 10)) begin
            return 1'b0;
        end
        case (int'(a))
            13, 17, 24, 32, 34, 38, 46, 51, 56, 57, 62, 63, 76, 84: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic cell_t cell_code(input logic [RW-1:0] r, input logic [CW-1:0] c,
                                        input logic [AW-1:0] a, input mode_t m,
                                        input logic [3:0] rnd);
        if (is_border(r, c))  return CELL_BLOCK;
        if (is_spawn_a(r, c)) return CELL_PLAYER_A;
        if (is_spawn_b(r, c)) return CELL_PLAYER_B;
        if (is_safe(r, c))    return CELL_BLANK;
        case (m)
            MODE_PILLARS: return (!r[0] && !c[0]) ? CELL_BLOCK : CELL_BLANK;
            MODE_LEGACY:  return legacy_hit(a) ? CELL_BLOCK : CELL_BLANK;
            MODE_RANDOM:  return ({1'b0, rnd} < 5'(DENSITY)) ? CELL_BLOCK : CELL_BLANK;
            default:      return CELL_BLANK;
        endcase
    endfunction

    // Next state and next registered outputs; each FILL cycle prepares the following cell.
    always_comb begin
        state_d   = state_q;
        r_d       = r_q;
        c_d       = c_q;
        base_d    = base_q;
        mode_d    = mode_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        we_d      = 1'b0;
        addr_d    = '0;
        data_d    = CELL_BLANK;
        ha_d      = ha_q;
        hb_d      = hb_q;
        gs_d      = gs_q;
        lfsr_load = 1'b0;
        lfsr_seed = (bus.seed == 16'h0000) ? LFSR_DEFAULT_SEED : bus.seed;
        lfsr_adv  = 1'b0;
        nr        = r_q;
        nc        = c_q;
        nbase     = base_q;
        emit      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d   = ST_FILL;
                    mode_d    = mode_t'(bus.mode);
                    lfsr_load = 1'b1;
                    gs_d      = GS_LOADING;
                    nr        = '0;
                    nc        = '0;
                    nbase     = '0;
                    emit      = 1'b1;
                end
            end
            ST_FILL: begin
                if ((r_q == RW'(ROWS - 1)) && (c_q == CW'(COLS - 1))) begin
                    state_d = ST_FINISH;
                    done_d  = 1'b1;
                    ha_d    = 2'(HEALTH_INIT);
                    hb_d    = 2'(HEALTH_INIT);
                    gs_d    = GS_PLAY;
                end else begin
                    if (c_q == CW'(COLS - 1)) begin
                        nc    = '0;
                        nr    = r_q + RW'(1);
                        nbase = base_q + AW'(COLS);
                    end else begin
                        nc    = c_q + CW'(1);
                    end
                    emit = 1'b1;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (emit) begin
            r_d      = nr;
            c_d      = nc;
            base_d   = nbase;
            busy_d   = 1'b1;
            we_d     = 1'b1;
            addr_d   = nbase + AW'(nc);
            data_d   = cell_code(nr, nc, addr_d, mode_d, lfsr_q[3:0]);
            lfsr_adv = (mode_d == MODE_RANDOM) && is_rule(nr, nc) && !lfsr_load;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            r_q     <= '0;
            c_q     <= '0;
            base_q  <= '0;
            mode_q  <= MODE_EMPTY;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= CELL_BLANK;
            ha_q    <= 2'd0;
            hb_q    <= 2'd0;
            gs_q    <= GS_LOADING;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            c_q     <= c_d;
            base_q  <= base_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            ha_q    <= ha_d;
            hb_q    <= hb_d;
            gs_q    <= gs_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.cell_we    = we_q;
    assign bus.bomb_we    = we_q;
    assign bus.cell_addr  = addr_q;
    assign bus.cell_data  = data_q;
    assign bus.healthA    = ha_q;
    assign bus.healthB    = hb_q;
    assign bus.game_state = gs_q;

endmodule

// File: tb/tb_arena_loader.sv
// Directed bench for arena_loader: timing, layouts, reset behaviour and a non-square arena.
module tb_arena_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  mode;
    logic [15:0] seed;
    logic        clr;

    int vectors;
    int errs;

    arena_loader_if #(.ROWS(10), .COLS(10)) ia ();
    arena_loader_if #(.ROWS(10), .COLS(10)) ib ();
    arena_loader_if #(.ROWS(10), .COLS(10)) ic ();
    arena_loader_if #(.ROWS(7),  .COLS(12)) id ();

    assign ia.start = start; assign ia.mode = mode; assign ia.seed = seed;
    assign ib.start = start; assign ib.mode = mode; assign ib.seed = seed;
    assign ic.start = start; assign ic.mode = mode; assign ic.seed = seed;
    assign id.start = start; assign id.mode = mode; assign id.seed = seed;

    arena_loader #(.ROWS(10), .COLS(10), .HEALTH_INIT(3), .DENSITY(5))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
    arena_loader #(.ROWS(10), .COLS(10), .HEALTH_INIT(3), .DENSITY(0))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));
    arena_loader #(.ROWS(10), .COLS(10), .HEALTH_INIT(3), .DENSITY(16))
        dut_c (.clk(clk), .rst_n(rst_n), .bus(ic));
    arena_loader #(.ROWS(7), .COLS(12), .HEALTH_INIT(3), .DENSITY(5))
        dut_d (.clk(clk), .rst_n(rst_n), .bus(id));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] img_a [100];
    logic [1:0] img_b [100];
    logic [1:0] img_c [100];
    logic [1:0] img_d [84];
    logic [1:0] img_s [100];
    int wr_a, ord_a, bomb_a, done_a, exp_a;
    int wr_d, done_d;

    // Capture the written images of the 10x10 instances.
    always @(negedge clk) begin
        if (clr) begin
            wr_a = 0; ord_a = 0; bomb_a = 0; done_a = 0; exp_a = 0;
            for (int k = 0; k < 100; k++) begin
                img_a[k] = 2'bxx; img_b[k] = 2'bxx; img_c[k] = 2'bxx;
            end
        end else begin
            if (ia.cell_we === 1'b1) begin
                img_a[int'(ia.cell_addr)] = ia.cell_data;
                if (int'(ia.cell_addr) != exp_a) ord_a++;
                exp_a = int'(ia.cell_addr) + 1;
                wr_a++;
            end
            if (ia.bomb_we === 1'b1) bomb_a++;
            if (ia.done === 1'b1) done_a++;
            if (ib.cell_we === 1'b1) img_b[int'(ib.cell_addr)] = ib.cell_data;
            if (ic.cell_we === 1'b1) img_c[int'(ic.cell_addr)] = ic.cell_data;
        end
    end

    // Capture the 7x12 instance.
    always @(negedge clk) begin
        if (clr) begin
            wr_d = 0; done_d = 0;
            for (int k = 0; k < 84; k++) img_d[k] = 2'bxx;
        end else begin
            if (id.cell_we === 1'b1) begin
                if (int'(id.cell_addr) < 84) img_d[int'(id.cell_addr)] = id.cell_data;
                wr_d++;
            end
            if (id.done === 1'b1) done_d++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected 10x10 cell code; m=4 stands for "every layout-decided cell is a block".
    function automatic logic [1:0] model(input int r, input int c, input int m);
        int legacy [14];
        int da, db;
        legacy = '{13, 17, 24, 32, 34, 38, 46, 51, 56, 57, 62, 63, 76, 84};
        if (r == 0 || r == 9 || c == 0 || c == 9) return 2'b01;
        if (r == 1 && c == 1) return 2'b10;
        if (r == 8 && c == 8) return 2'b11;
        da = ((r > 1) ? r - 1 : 1 - r) + ((c > 1) ? c - 1 : 1 - c);
        db = ((r > 8) ? r - 8 : 8 - r) + ((c > 8) ? c - 8 : 8 - c);
        if (da == 1 || db == 1) return 2'b00;
        if (m == 1) return (r % 2 == 0 && c % 2 == 0) ? 2'b01 : 2'b00;
        if (m == 2) begin
            foreach (legacy[k]) if (r * 10 + c == legacy[k]) return 2'b01;
            return 2'b00;
        end
        if (m == 4) return 2'b01;
        return 2'b00;
    endfunction

    function automatic int img_diff(input logic [1:0] img [100], input int m);
        int n = 0;
        for (int k = 0; k < 100; k++) if (img[k] !== model(k / 10, k % 10, m)) n++;
        return n;
    endfunction

    task automatic clear_mon();
        @(posedge clk); clr = 1'b1;
        @(posedge clk); clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic kick(input logic [1:0] m, input logic [15:0] s);
        mode = m; seed = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        logic seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ia.done === 1'b1) begin seen = 1'b1; break; end
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    initial begin
        vectors = 0; errs = 0; clr = 1'b0;
        rst_n = 1'b0; start = 1'b1; mode = 2'd0; seed = 16'h0;
        repeat (3) @(negedge clk);
        chk("rst_busy",  32'(ia.busy), 0);
        chk("rst_done",  32'(ia.done), 0);
        chk("rst_we",    32'(ia.cell_we), 0);
        chk("rst_bomb",  32'(ia.bomb_we), 0);
        chk("rst_addr",  32'(ia.cell_addr), 0);
        chk("rst_data",  32'(ia.cell_data), 0);
        chk("rst_hA",    32'(ia.healthA), 0);
        chk("rst_hB",    32'(ia.healthB), 0);
        chk("rst_gs",    32'(ia.game_state), 3);
        rst_n = 1'b1; start = 1'b0;
        @(negedge clk);
        chk("rst_start_ignored", 32'(ia.cell_we), 0);

        // Mode 0 with cycle-exact timing.
        clear_mon();
        kick(2'd0, 16'h0);
        chk("m0_first_we",   32'(ia.cell_we), 1);
        chk("m0_first_bomb", 32'(ia.bomb_we), 1);
        chk("m0_first_busy", 32'(ia.busy), 1);
        chk("m0_first_addr", 32'(ia.cell_addr), 0);
        chk("m0_first_data", 32'(ia.cell_data), 1);
        chk("m0_load_gs",    32'(ia.game_state), 3);
        chk("m0_load_hA",    32'(ia.healthA), 0);
        repeat (99) @(negedge clk);
        chk("m0_last_we",    32'(ia.cell_we), 1);
        chk("m0_last_addr",  32'(ia.cell_addr), 99);
        @(negedge clk);
        chk("m0_done",       32'(ia.done), 1);
        chk("m0_fin_busy",   32'(ia.busy), 0);
        chk("m0_fin_we",     32'(ia.cell_we), 0);
        chk("m0_fin_addr",   32'(ia.cell_addr), 0);
        chk("m0_fin_data",   32'(ia.cell_data), 0);
        chk("m0_fin_hA",     32'(ia.healthA), 3);
        chk("m0_fin_hB",     32'(ia.healthB), 3);
        chk("m0_fin_gs",     32'(ia.game_state), 0);
        @(negedge clk);
        chk("m0_done_pulse", 32'(ia.done), 0);
        chk("m0_hold_hA",    32'(ia.healthA), 3);
        chk("m0_writes",     32'(wr_a), 100);
        chk("m0_order",      32'(ord_a), 0);
        chk("m0_bombs",      32'(bomb_a), 100);
        chk("m0_addr11",     32'(img_a[11]), 2);
        chk("m0_addr88",     32'(img_a[88]), 3);
        chk("m0_addr55",     32'(img_a[55]), 0);
        chk("m0_image",      32'(img_diff(img_a, 0)), 0);
        chk("m0_d0_image",   32'(img_diff(img_b, 0)), 0);
        chk("r7c12_writes",  32'(wr_d), 84);
        chk("r7c12_spawnB",  32'(img_d[70]), 3);
        chk("r7c12_spawnA",  32'(img_d[13]), 2);
        chk("r7c12_done",    32'(done_d), 1);

        // Mode 1 with start held high through FILL and FINISH.
        clear_mon();
        mode = 2'd1; start = 1'b1;
        wait_done("m1_done_seen");
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("m1_no_restart", 32'(ia.cell_we), 0);
        chk("m1_one_done",   32'(done_a), 1);
        chk("m1_writes",     32'(wr_a), 100);
        chk("m1_addr22",     32'(img_a[22]), 1);
        chk("m1_addr12",     32'(img_a[12]), 0);
        chk("m1_addr21",     32'(img_a[21]), 0);
        chk("m1_addr44",     32'(img_a[44]), 1);
        chk("m1_image",      32'(img_diff(img_a, 1)), 0);

        // Mode 2 legacy layout; health kept across a new load.
        clear_mon();
        kick(2'd2, 16'h0);
        chk("m2_load_gs",    32'(ia.game_state), 3);
        chk("m2_load_hA",    32'(ia.healthA), 3);
        wait_done("m2_done_seen");
        @(negedge clk);
        chk("m2_bombs",      32'(bomb_a), 100);
        chk("m2_addr13",     32'(img_a[13]), 1);
        chk("m2_addr84",     32'(img_a[84]), 1);
        chk("m2_addr14",     32'(img_a[14]), 0);
        chk("m2_image",      32'(img_diff(img_a, 2)), 0);

        // Mode 3: seed 0 substitutes the default seed.
        clear_mon();
        kick(2'd3, 16'h0000);
        wait_done("m3_s0_done");
        @(negedge clk);
        for (int k = 0; k < 100; k++) img_s[k] = img_a[k];
        clear_mon();
        kick(2'd3, 16'hACE1);
        wait_done("m3_ace1_done");
        @(negedge clk);
        begin
            int nd = 0;
            for (int k = 0; k < 100; k++) if (img_a[k] !== img_s[k]) nd++;
            chk("m3_seed0_same", 32'(nd), 0);
        end
        chk("m3_dens0",      32'(img_diff(img_b, 0)), 0);
        chk("m3_dens16",     32'(img_diff(img_c, 4)), 0);

        // Reset in the middle of a load, then a clean reload.
        clear_mon();
        kick(2'd0, 16'h0);
        repeat (39) @(negedge clk);
        chk("mid_addr39",    32'(ia.cell_addr), 39);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_we",    32'(ia.cell_we), 0);
        chk("mid_rst_busy",  32'(ia.busy), 0);
        chk("mid_rst_gs",    32'(ia.game_state), 3);
        chk("mid_rst_hA",    32'(ia.healthA), 0);
        chk("mid_rst_addr",  32'(ia.cell_addr), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_idle_we",   32'(ia.cell_we), 0);
        clear_mon();
        kick(2'd0, 16'h0);
        chk("re_first_addr", 32'(ia.cell_addr), 0);
        wait_done("re_done");
        @(negedge clk);
        chk("re_writes",     32'(wr_a), 100);
        chk("re_order",      32'(ord_a), 0);
        chk("re_image",      32'(img_diff(img_a, 0)), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
